toggle_event_rx: RTL and testbench
==================================

Name: toggle_event_rx

Overview:
- Receiving end of the toggle-line event protocol; the sending end is a T flip-flop whose output Y inverts once per event.
- Samples the incoming toggle level and turns each level change into one queued event.
- Holds a count of pending events and hands them to a consumer over a VALID/ACK handshake.
- Sits at the consumer side of any link driven by the team's T flip-flop.

Parameters:
- CNT_W, 4: width of the pending-event counter; MAX = 2^CNT_W - 1.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset; clears all state immediately.
- ENABLE  input  1  when 1, detected toggles are queued; when 0, they are discarded.
- T_IN  input  1  toggle line from the transmitter (the T flip-flop output Y).
- ACK  input  1  consumer takes one event; effective only while VALID = 1.
- VALID  output  1  1 while at least one event is pending.
- COUNT  output  CNT_W  number of pending events.
- OVF  output  1  sticky flag: an event was lost because the counter was saturated.

Behaviour:
- Reset (asynchronous, RST = 1): sync flops = 0, t_q = 0, armed = 0, COUNT = 0, VALID = 0, OVF = 0, state = EMPTY.
- Sampling:
  - T_IN passes through the sample stage (see Optional Feature) to produce s.
  - t_q <= s on every cycle, whether ENABLE is 0 or 1.
- Arming: armed goes to 1 on the first rising edge after RST drops. Until armed = 1, no toggle is detected. This stops a T_IN that is already 1 at reset release from creating an event.
- Toggle detect: tog = armed & ENABLE & (s ^ t_q). It is one cycle wide. A toggle that occurs while ENABLE = 0 is dropped, and no event is produced later when ENABLE returns to 1.
- Handshake:
  - take = VALID & ACK.
  - ACK while VALID = 0 is ignored.
- Counter update, per rising edge:
  - tog & !take: COUNT + 1, unless COUNT = MAX. At MAX, COUNT holds and OVF <= 1.
  - take & !tog: COUNT - 1.
  - tog & take: COUNT unchanged. This holds at MAX too, and OVF does not set.
  - neither: hold.
- State machine (registered, consistent with COUNT):
  - States: EMPTY (COUNT = 0), AVAIL (0 < COUNT < MAX), FULL (COUNT = MAX).
  - EMPTY -> AVAIL on tog.
  - AVAIL -> FULL on tog & !take when COUNT = MAX-1.
  - AVAIL -> EMPTY on take & !tog when COUNT = 1.
  - FULL -> AVAIL on take & !tog.
  - FULL stays FULL on tog & !take (overflow case).
  - VALID = (state != EMPTY), registered, so it is valid in the same cycle as COUNT.
- Latency from a T_IN change to VALID (ENABLE = 1, armed, COUNT was 0):
  - with the feature: VALID high after the 3rd rising edge following the change;
  - without the feature: after the 2nd.
- OVF: cleared only by RST.
- Reset mid-operation: pending events are lost, and armed must set again before new detection. The transmitter is not reset by this block.
- Toggle rate: the transmitter must hold each level for at least 2 CLK cycles. Faster toggling is outside the protocol.

Optional Feature:
- Macro: TOGGLE_RX_SYNC_EN.
- Defined:
  - T_IN passes through a 2-flop synchronizer, s = second flop.
  - For an asynchronous transmitter.
- Undefined:
  - single sample register, s = T_IN registered once.
  - For a same-clock transmitter.
  - Latency drops by 1 cycle.
- Handshake and counter behaviour are identical in both builds.

Decomposition:
- Package toggle_rx_pkg:
  - state enum {EMPTY, AVAIL, FULL};
  - default CNT_W = 4;
  - localparam function for MAX.
- Sub-module toggle_sync:
  - sample or synchronizer stage, t_q register, arming bit;
  - outputs the one-cycle tog pulse;
  - owns the TOGGLE_RX_SYNC_EN selection.
- The top level holds the counter, FSM and OVF.

Test Plan:
- Reset with T_IN = 1 held, release RST -> no event; COUNT = 0, VALID = 0 for 10 cycles.
- ENABLE = 1, toggle T_IN 0->1->0 (each level held 4 cycles), ACK = 0 -> COUNT = 2, VALID = 1, with the first VALID at the latency stated above for each build.
- COUNT = 2, ACK held 1 -> COUNT 1, then 0; VALID drops the cycle COUNT reaches 0; further ACK leaves COUNT = 0.
- ENABLE = 0, toggle T_IN 3 times, then ENABLE = 1 with no new toggle -> COUNT stays 0.
- CNT_W = 2, 4 toggles with ACK = 0 -> COUNT = 3, state FULL, OVF = 1; a toggle together with ACK at FULL -> COUNT = 3, no new OVF event.
- COUNT = 1, toggle and ACK in the same cycle -> COUNT = 1, VALID stays 1; assert RST mid-stream -> all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/toggle_rx_pkg.sv
// toggle_rx_pkg: shared types and constants for the toggle-line event receiver.
//   state_e   - occupancy state of the pending-event counter
//   DEF_CNT_W - default counter width
//   cnt_max   - saturation value for a counter of a given width
package toggle_rx_pkg;

    localparam int unsigned DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        EMPTY,  // count == 0
        AVAIL,  // 0 < count < max
        FULL    // count == max
    } state_e;

    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/toggle_event_rx_if.sv
// toggle_event_rx_if: toggle line, enable and VALID/ACK handshake of the receiver.
//   enable - queue detected toggles when 1, discard them when 0
//   t_in   - toggle line from the transmitting T flip-flop
//   ack    - consumer takes one event (only while valid)
//   valid  - at least one event pending
//   count  - number of pending events
//   ovf    - sticky: an event was lost at saturation
// Modports: master = transmitter/consumer side, slave = receiver.
interface toggle_event_rx_if #(
    parameter int unsigned CNT_W = toggle_rx_pkg::DEF_CNT_W
);
    logic             enable;
    logic             t_in;
    logic             ack;
    logic             valid;
    logic [CNT_W-1:0] count;
    logic             ovf;

    modport master (output enable, output t_in, output ack,
                    input valid, input count, input ovf);
    modport slave  (input enable, input t_in, input ack,
                    output valid, output count, output ovf);
endinterface

// File: rtl/toggle_sync.sv
// toggle_sync: samples the toggle line and emits a one-cycle pulse per level change.
//   clk, rst - clock, asynchronous active-high reset
//   enable   - gates the pulse; toggles seen while 0 are dropped for good
//   t_in     - toggle line
//   tog      - one-cycle pulse per detected level change
// Build option: TOGGLE_RX_SYNC_EN selects a 2-flop synchronizer (asynchronous
// transmitter); otherwise a single sample register is used (same-clock transmitter).
module toggle_sync (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic t_in,
    output logic tog
);
    logic s;
    logic t_q;
    logic armed;

`ifdef TOGGLE_RX_SYNC_EN
    logic sync1;

    // On the arming edge every stage loads the current line level, so a line
    // that is already high at reset release does not look like a toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            t_q   <= 1'b0;
            armed <= 1'b0;
        end else if (!armed) begin
            sync1 <= t_in;
            s     <= t_in;
            t_q   <= t_in;
            armed <= 1'b1;
        end else begin
            sync1 <= t_in;
            s     <= sync1;
            t_q   <= s;
        end
    end
`else
    // Same arming preload as the synchronized build, with one sample stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s     <= 1'b0;
            t_q   <= 1'b0;
            armed <= 1'b0;
        end else if (!armed) begin
            s     <= t_in;
            t_q   <= t_in;
            armed <= 1'b1;
        end else begin
            s     <= t_in;
            t_q   <= s;
        end
    end
`endif

    assign tog = armed & enable & (s ^ t_q);

endmodule

// File: rtl/toggle_event_rx.sv
// toggle_event_rx: turns level changes on a toggle line into queued events and
// hands them to a consumer over a VALID/ACK handshake.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - toggle_event_rx_if.slave (enable, t_in, ack in; valid, count, ovf out)
// Build option: TOGGLE_RX_SYNC_EN (see toggle_sync) adds one cycle of latency.
// CNT_W must be at least 2 so that EMPTY, AVAIL and FULL are distinct counts.
module toggle_event_rx
    import toggle_rx_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input logic              clk,
    input logic              rst,
    toggle_event_rx_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

    logic             tog;
    logic             take;
    state_e           state;
    logic [CNT_W-1:0] count_q;
    logic             valid_q;
    logic             ovf_q;

    toggle_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .enable (bus.enable),
        .t_in   (bus.t_in),
        .tog    (tog)
    );

    assign take = valid_q & bus.ack;

    // A simultaneous toggle and take cancel out in every state, so FULL never
    // flags an overflow when the consumer frees a slot in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (tog) begin
                        count_q <= count_q + 1'b1;
                        valid_q <= 1'b1;
                        state   <= AVAIL;
                    end
                end
                AVAIL: begin
                    if (tog && !take) begin
                        count_q <= count_q + 1'b1;
                        if (count_q == MAX - 1'b1) begin
                            state <= FULL;
                        end
                    end else if (take && !tog) begin
                        count_q <= count_q - 1'b1;
                        if (count_q == CNT_W'(1)) begin
                            valid_q <= 1'b0;
                            state   <= EMPTY;
                        end
                    end
                end
                FULL: begin
                    if (take && !tog) begin
                        count_q <= count_q - 1'b1;
                        state   <= AVAIL;
                    end else if (tog && !take) begin
                        ovf_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    count_q <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valid = valid_q;
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_toggle_event_rx.sv
// Bench for toggle_event_rx: a CNT_W=4 and a CNT_W=2 instance share stimulus.
module tb_toggle_event_rx;

`ifdef TOGGLE_RX_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    toggle_event_rx_if #(.CNT_W(4)) if4 ();
    toggle_event_rx_if #(.CNT_W(2)) if2 ();

    toggle_event_rx #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    toggle_event_rx #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] c4;
        logic       v4;
        logic       o4;
        logic [1:0] c2;
        logic       v2;
        logic       o2;
    } exp_t;

    typedef struct {
        logic en;
        logic t;
        logic ack;
        int   n;
        int   c4;
        int   c2;
        logic v;
        logic o2;
    } row_t;

    exp_t sb[$];
    row_t rows[17];

    // Reference model: line samples delayed by D stages, plus counters.
    logic [3:0] mc4;
    logic [1:0] mc2;
    logic       mo4, mo2, marm;
    logic       mp [0:2];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mc4 = '0; mc2 = '0; mo4 = 1'b0; mo2 = 1'b0; marm = 1'b0;
        for (int i = 0; i < 3; i++) mp[i] = 1'b0;
        sb.delete();
    endtask

    task automatic model_step(input logic en, input logic t, input logic ack);
        logic tg, tk4, tk2;
        tg  = marm && en && (mp[D-1] != mp[D]);
        tk4 = (mc4 != 0) && ack;
        tk2 = (mc2 != 0) && ack;
        if (tg && !tk4) begin
            if (mc4 == 4'hF) mo4 = 1'b1; else mc4 = mc4 + 4'd1;
        end else if (tk4 && !tg) mc4 = mc4 - 4'd1;
        if (tg && !tk2) begin
            if (mc2 == 2'h3) mo2 = 1'b1; else mc2 = mc2 + 2'd1;
        end else if (tk2 && !tg) mc2 = mc2 - 2'd1;
        if (!marm) begin
            for (int i = 0; i <= D; i++) mp[i] = t;
            marm = 1'b1;
        end else begin
            for (int i = D; i > 0; i--) mp[i] = mp[i-1];
            mp[0] = t;
        end
    endtask

    // One clock: drive inputs just after an edge, predict, compare after next edge.
    task automatic cyc(input logic en, input logic t, input logic ack);
        exp_t e;
        if4.enable = en; if4.t_in = t; if4.ack = ack;
        if2.enable = en; if2.t_in = t; if2.ack = ack;
        model_step(en, t, ack);
        sb.push_back('{c4: mc4, v4: (mc4 != 0), o4: mo4, c2: mc2, v2: (mc2 != 0), o2: mo2});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb count4", int'(if4.count), int'(e.c4));
        check("sb valid4", int'(if4.valid), int'(e.v4));
        check("sb ovf4",   int'(if4.ovf),   int'(e.o4));
        check("sb count2", int'(if2.count), int'(e.c2));
        check("sb valid2", int'(if2.valid), int'(e.v2));
        check("sb ovf2",   int'(if2.ovf),   int'(e.o2));
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            for (int k = 0; k < rows[r].n; k++) cyc(rows[r].en, rows[r].t, rows[r].ack);
            check($sformatf("row%0d count4", r), int'(if4.count), rows[r].c4);
            check($sformatf("row%0d count2", r), int'(if2.count), rows[r].c2);
            check($sformatf("row%0d valid4", r), int'(if4.valid), int'(rows[r].v));
            check($sformatf("row%0d valid2", r), int'(if2.valid), int'(rows[r].v));
            check($sformatf("row%0d ovf4", r),   int'(if4.ovf),   0);
            check($sformatf("row%0d ovf2", r),   int'(if2.ovf),   int'(rows[r].o2));
        end
    endtask

    task automatic check_zero(input string name);
        check({name, " count4"}, int'(if4.count), 0);
        check({name, " valid4"}, int'(if4.valid), 0);
        check({name, " ovf4"},   int'(if4.ovf),   0);
        check({name, " count2"}, int'(if2.count), 0);
        check({name, " valid2"}, int'(if2.valid), 0);
        check({name, " ovf2"},   int'(if2.ovf),   0);
    endtask

    initial begin
        int lat;
        //            en    t     ack   n   c4 c2 v     o2
        rows[0]  = '{1'b1, 1'b1, 1'b0, 10, 0, 0, 1'b0, 1'b0};
        rows[1]  = '{1'b1, 1'b1, 1'b0, 4,  2, 2, 1'b1, 1'b0};
        rows[2]  = '{1'b1, 1'b1, 1'b1, 1,  1, 1, 1'b1, 1'b0};
        rows[3]  = '{1'b1, 1'b1, 1'b1, 1,  0, 0, 1'b0, 1'b0};
        rows[4]  = '{1'b1, 1'b1, 1'b1, 3,  0, 0, 1'b0, 1'b0};
        rows[5]  = '{1'b0, 1'b0, 1'b0, 4,  0, 0, 1'b0, 1'b0};
        rows[6]  = '{1'b0, 1'b1, 1'b0, 4,  0, 0, 1'b0, 1'b0};
        rows[7]  = '{1'b0, 1'b0, 1'b0, 4,  0, 0, 1'b0, 1'b0};
        rows[8]  = '{1'b1, 1'b0, 1'b0, 6,  0, 0, 1'b0, 1'b0};
        rows[9]  = '{1'b1, 1'b1, 1'b0, 4,  1, 1, 1'b1, 1'b0};
        rows[10] = '{1'b1, 1'b0, 1'b0, 4,  2, 2, 1'b1, 1'b0};
        rows[11] = '{1'b1, 1'b1, 1'b0, 4,  3, 3, 1'b1, 1'b0};
        rows[12] = '{1'b1, 1'b1, 1'b0, 4,  4, 3, 1'b1, 1'b1};
        rows[13] = '{1'b1, 1'b1, 1'b1, 6,  0, 0, 1'b0, 1'b1};
        rows[14] = '{1'b1, 1'b0, 1'b0, 4,  1, 1, 1'b1, 1'b1};
        rows[15] = '{1'b1, 1'b1, 1'b0, 6,  0, 0, 1'b0, 1'b0};
        rows[16] = '{1'b1, 1'b0, 1'b0, 4,  1, 1, 1'b1, 1'b0};

        // Reset held with the line already high.
        if4.enable = 1'b1; if4.t_in = 1'b1; if4.ack = 1'b0;
        if2.enable = 1'b1; if2.t_in = 1'b1; if2.ack = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // High line at release must not produce an event.
        run_rows(0, 0);

        // First event latency from the line change.
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (lat == 0 && if4.valid) lat = i;
        end
        check("latency edges", lat, D + 1);

        // Accumulate, drain, ignored ack, disabled toggles, fill to FULL.
        run_rows(1, 11);

        // Toggle and ack landing on the same edge at FULL: count holds, no overflow.
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b0, (i == D + 1));
            check("full tog+ack count2", int'(if2.count), 3);
            check("full tog+ack count4", int'(if4.count), 3);
            check("full tog+ack ovf2",   int'(if2.ovf),   0);
        end

        // Overflow on the narrow counter, drain, single event.
        run_rows(12, 14);

        // Toggle and ack on the same edge with one pending.
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b1, (i == D + 1));
            check("one tog+ack count4", int'(if4.count), 1);
            check("one tog+ack count2", int'(if2.count), 1);
            check("one tog+ack valid4", int'(if4.valid), 1);
        end

        // Asynchronous reset between edges clears everything at once.
        #2;
        rst = 1'b1;
        #1;
        check_zero("async reset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Re-arm with the line high, then a fresh event.
        run_rows(15, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
